// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: phase sequencer, lives/level/BCD score and ball-step pacing for 8x8 breakout.
module breakout_game_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int STEP_DIV_INIT = 3,
  parameter int HOLD_TICKS    = 20
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic       throw_i,
  input  logic       ball_miss_i,
  input  logic       brick_hit_i,
  input  logic [4:0] bricks_left_i,
  output logic [2:0] phase_o,
  output logic       hands_on_o,
  output logic       ball_step_o,
  output logic       field_init_o,
  output logic [1:0] lives_o,
  output logic [2:0] level_o,
  output logic [3:0] score_ones_o,
  output logic [3:0] score_tens_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, MISS = 3'd3, CLEAR = 3'd4, OVER = 3'd5} phase_e;
  phase_e state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [2:0] level_q, level_d, step_div_q, step_div_d, step_cnt_q, step_cnt_d;
  logic [3:0] ones_q, ones_d, tens_q, tens_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       throw_q, hands_on_q, hands_on_d, ball_step_q, ball_step_d, field_init_q, field_init_d;
  logic       throw_rise, step_hit, hold_done, score_sat;
  logic [2:0] level_nx;
  assign throw_rise = throw_i & ~throw_q;
  assign step_hit   = tick_i && (step_cnt_q == step_div_q - 3'd1);
  assign hold_done  = tick_i && (hold_cnt_q == 8'(HOLD_TICKS - 1));
  assign score_sat  = (ones_q == 4'd9) && (tens_q == 4'd9);
  assign level_nx   = (level_q == 3'd7) ? 3'd7 : level_q + 3'd1;
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    step_div_d   = step_div_q;
    step_cnt_d   = step_cnt_q;
    ones_d       = ones_q;
    tens_d       = tens_q;
    hold_cnt_d   = hold_cnt_q;
    ball_step_d  = 1'b0;
    field_init_d = 1'b0;
    if (state_q != IDLE && !start_i) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_d      = SERVE;
          field_init_d = 1'b1;
          lives_d      = 2'(LIVES_INIT);
          level_d      = 3'd1;
          ones_d       = 4'd0;
          tens_d       = 4'd0;
          step_div_d   = 3'(STEP_DIV_INIT);
        end
        SERVE: if (throw_rise) begin
          state_d    = PLAY;
          step_cnt_d = 3'd0;
        end
        PLAY: begin
          if (brick_hit_i && !score_sat) begin
            ones_d = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
            tens_d = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
          end
          if (tick_i) step_cnt_d = step_hit ? 3'd0 : step_cnt_q + 3'd1;
          // clearing the field outranks a simultaneous miss; any transition swallows the step
          if (bricks_left_i == 5'd0) begin
            state_d      = CLEAR;
            level_d      = level_nx;
            step_div_d   = (level_nx >= 3'(STEP_DIV_INIT)) ? 3'd1 : 3'(STEP_DIV_INIT) - level_nx + 3'd1;
            field_init_d = 1'b1;
            hold_cnt_d   = 8'd0;
          end else if (ball_miss_i) begin
            state_d    = (lives_q > 2'd1) ? MISS : OVER;
            lives_d    = lives_q - 2'd1;
            hold_cnt_d = 8'd0;
          end else ball_step_d = step_hit;
        end
        MISS, CLEAR: if (tick_i) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
          if (hold_done) state_d = SERVE;
        end
        default: ;
      endcase
    end
    hands_on_d = (state_d != PLAY) && (state_d != OVER);
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      lives_q      <= 2'(LIVES_INIT);
      level_q      <= 3'd1;
      step_div_q   <= 3'(STEP_DIV_INIT);
      step_cnt_q   <= 3'd0;
      ones_q       <= 4'd0;
      tens_q       <= 4'd0;
      hold_cnt_q   <= 8'd0;
      throw_q      <= 1'b0;
      hands_on_q   <= 1'b1;
      ball_step_q  <= 1'b0;
      field_init_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      step_div_q   <= step_div_d;
      step_cnt_q   <= step_cnt_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      hold_cnt_q   <= hold_cnt_d;
      throw_q      <= throw_i;
      hands_on_q   <= hands_on_d;
      ball_step_q  <= ball_step_d;
      field_init_q <= field_init_d;
    end
  end
  assign phase_o      = state_q;
  assign hands_on_o   = hands_on_q;
  assign ball_step_o  = ball_step_q;
  assign field_init_o = field_init_q;
  assign lives_o      = lives_q;
  assign level_o      = level_q;
  assign score_ones_o = ones_q;
  assign score_tens_o = tens_q;
endmodule
